riscv_data_mem_responder: RTL and testbench

- Memory-side responder for the multi-cycle RISC-V core's data bus.
- Serves word, halfword and byte loads with sign/zero extension, and word, halfword and byte stores, from a word-wide synchronous RAM.
- Sub-word stores use an internal read-modify-write sequence.
- Sits between the core's Address/WriteData/MemWrite/ReadData port and the .data storage; adds a request/ready handshake.

---
 rtl/riscv_data_mem_responder_pkg.sv | 14 +
 rtl/riscv_data_mem_responder_if.sv | 20 ++
 rtl/riscv_data_mem_responder_lane_align.sv | 31 +++
 rtl/riscv_data_mem_responder.sv | 108 ++++++++++
 tb/tb_riscv_data_mem_responder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_data_mem_responder_pkg.sv
// riscv_mem_pkg: size codes, FSM states and Funct3 legality shared by the data memory responder
package riscv_mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, RESP, MERGE} state_t;

    function automatic logic is_legal_f3(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction
endpackage

// File: rtl/riscv_data_mem_responder_if.sv
// riscv_data_mem_responder_if: core data-bus request/response bundle with a ready handshake
interface riscv_data_mem_responder_if;
    logic        MemReq;
    logic [31:0] Address;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Err;

    modport master (
        output MemReq, Address, MemWrite, Funct3, WriteData,
        input  ReadData, Ready, Err
    );
    modport slave (
        input  MemReq, Address, MemWrite, Funct3, WriteData,
        output ReadData, Ready, Err
    );
endinterface

// File: rtl/riscv_data_mem_responder_lane_align.sv
// riscv_lane_align: byte-lane extract/extend for loads, lane merge for stores, misalignment detect
module riscv_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word,
    output logic        misalign
);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    always_comb begin
        b = word[{offset, 3'b000} +: 8];
        h = word[{offset[1], 4'b0000} +: 16];
        load_value = funct3 == F3_B  ? {{24{b[7]}}, b} :
                     funct3 == F3_BU ? {24'd0, b} :
                     funct3 == F3_H  ? {{16{h[15]}}, h} :
                     funct3 == F3_HU ? {16'd0, h} : word;
        lane_mask = (funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {offset, 3'b000};
        lane_data = (funct3[0] ? {16'd0, store_data[15:0]} : {24'd0, store_data[7:0]}) << {offset, 3'b000};
        merged_word = funct3[1] ? store_data : (word & ~lane_mask) | (lane_data & lane_mask);
        misalign = funct3[1:0] == 2'b01 ? offset[0] :
                   funct3[1:0] == 2'b10 ? |offset : 1'b0;
    end
endmodule

// File: rtl/riscv_data_mem_responder.sv
// riscv_data_mem_responder: handshaked data-memory responder with sub-word loads and read-modify-write stores
module riscv_data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter string INIT_FILE   = "data.hex"
) (
    input logic                      clk,
    input logic                      reset,
    riscv_data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] ram_q;
    logic [31:0] wd_q;
    logic [31:0] rd_hold;
    logic [31:0] load_value;
    logic [31:0] merged_word;
    logic [31:0] resp_value;
    logic [AW-1:0] idx_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic        ready_q;
    logic        err_q;
    logic        misalign;
    logic        bad;
    logic        accept;
    logic        sw_now;
    logic        rmw;
    logic [1:0]  off_sel;
    logic [2:0]  f3_sel;

    // The aligner checks live request fields in IDLE and the latched ones afterwards.
    always_comb begin
        accept     = state == IDLE && bus.MemReq;
        off_sel    = state == IDLE ? bus.Address[1:0] : off_q;
        f3_sel     = state == IDLE ? bus.Funct3 : f3_q;
        bad        = (bus.Address >> (AW + 2)) != 32'd0 || misalign || !is_legal_f3(bus.Funct3);
        sw_now     = accept && !bad && bus.MemWrite && bus.Funct3 == F3_W;
        rmw        = bus.MemWrite && !bus.Funct3[1] && !bad;
        resp_value = err_q || we_q ? 32'd0 : load_value;
    end

    riscv_lane_align u_align (
        .offset      (off_sel),
        .funct3      (f3_sel),
        .word        (ram_q),
        .store_data  (wd_q),
        .load_value  (load_value),
        .merged_word (merged_word),
        .misalign    (misalign)
    );

    // Single port: a word store writes at accept, everything else reads; MERGE is write-only.
    always_ff @(posedge clk) begin
        if (sw_now)
            mem[bus.Address[AW+1:2]] <= bus.WriteData;
        else if (state == MERGE)
            mem[idx_q] <= merged_word;
        if (accept && !sw_now)
            ram_q <= mem[bus.Address[AW+1:2]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rd_hold <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.MemReq) begin
                    idx_q   <= bus.Address[AW+1:2];
                    off_q   <= bus.Address[1:0];
                    f3_q    <= bus.Funct3;
                    wd_q    <= bus.WriteData;
                    we_q    <= bus.MemWrite;
                    err_q   <= bad;
                    ready_q <= !rmw;
                    state   <= rmw ? MERGE : RESP;
                end
                MERGE: begin
                    state   <= RESP;
                    ready_q <= 1'b1;
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rd_hold <= resp_value;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Ready    = ready_q;
    assign bus.Err      = err_q;
    assign bus.ReadData = state == RESP ? resp_value : rd_hold;
endmodule

// File: tb/tb_riscv_data_mem_responder.sv
// tb_riscv_data_mem_responder: byte-array reference model with a per-cycle output compare
module tb_riscv_data_mem_responder;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    riscv_data_mem_responder_if bus();

    riscv_data_mem_responder #(.DEPTH_WORDS(DW), .INIT_FILE("")) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          exp_at = -1;
    logic        chk = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_data = '0;
    logic [31:0] exp_hold = '0;
    logic [31:0] got;
    byte unsigned bmem [4*DW];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
        n_cmp++;
        if (actual !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, actual, want, cyc);
        end
    endtask

    // Reference: memory as bytes, sizes from Funct3, extension by hand.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic err,
                                  output logic [31:0] data, output int lat);
        int sz;
        sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        err = a >= 32'(4*DW) || (a % sz) != 0 || f3 inside {3'd3, 3'd6, 3'd7};
        data = '0;
        lat = 1;
        if (err) return;
        if (we) begin
            for (int i = 0; i < sz; i++) bmem[a + i] = wd[8*i +: 8];
            lat = sz < 4 ? 2 : 1;
        end else begin
            for (int i = 0; i < sz; i++) data[8*i +: 8] = bmem[a + i];
            if (!f3[2] && sz < 4 && data[8*sz-1])
                for (int i = sz; i < 4; i++) data[8*i +: 8] = 8'hFF;
        end
    endfunction

    always @(negedge clk) if (chk) begin
        check("ready", 32'(bus.Ready), 32'(cyc == exp_at));
        if (bus.Ready) begin
            check("err", 32'(bus.Err), 32'(exp_err));
            check("rdata", bus.ReadData, exp_data);
            exp_hold = exp_data;
        end else begin
            check("err_idle", 32'(bus.Err), 32'd0);
            check("rdata_hold", bus.ReadData, exp_hold);
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit twist, output logic [31:0] rd);
        logic        e;
        logic [31:0] d;
        int          lat;
        bit          seen;
        @(negedge clk);
        model(we, f3, a, wd, e, d, lat);
        bus.MemReq = 1'b1;
        bus.MemWrite = we;
        bus.Funct3 = f3;
        bus.Address = a;
        bus.WriteData = wd;
        @(posedge clk);
        #1;
        exp_err = e;
        exp_data = d;
        exp_at = cyc + lat - 1;
        if (twist && lat == 2) begin
            @(negedge clk);
            bus.Address = a ^ 32'h4;
            bus.WriteData = ~wd;
        end
        rd = '0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (bus.Ready) begin
                rd = bus.ReadData;
                seen = 1'b1;
            end
        end
        bus.MemReq = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: no Ready for addr %h f3 %0d within 8 cycles", a, f3);
        end
    endtask

    logic [2:0] f3s [13] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    initial begin
        bus.MemReq = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Funct3 = '0;
        bus.Address = '0;
        bus.WriteData = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.Ready), 32'd0);
        check("rst_err", 32'(bus.Err), 32'd0);
        check("rst_rdata", bus.ReadData, 32'd0);
        reset = 1'b1;
        chk = 1'b1;

        for (int w = 0; w < DW; w++)
            do_req(1'b1, 3'd2, 32'(4*w), w == 16 ? 32'h8899_AABB : $urandom, 1'b0, got);

        do_req(1'b0, 3'd0, 32'h40, 32'h0, 1'b0, got); check("lb_40", got, 32'hFFFF_FFBB);
        do_req(1'b0, 3'd4, 32'h43, 32'h0, 1'b0, got); check("lbu_43", got, 32'h0000_0088);
        do_req(1'b0, 3'd1, 32'h42, 32'h0, 1'b0, got); check("lh_42", got, 32'hFFFF_8899);
        do_req(1'b0, 3'd5, 32'h40, 32'h0, 1'b0, got); check("lhu_40", got, 32'h0000_AABB);

        do_req(1'b1, 3'd0, 32'h41, 32'h12, 1'b0, got); check("sb_rdata", got, 32'h0);
        do_req(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, got); check("lw_after_sb", got, 32'h8899_12BB);

        do_req(1'b1, 3'd1, 32'h42, 32'hCAFE, 1'b1, got);
        do_req(1'b1, 3'd2, 32'h44, 32'h0123_4567, 1'b0, got);
        do_req(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, got); check("lw_40_sh", got, 32'hCAFE_12BB);
        do_req(1'b0, 3'd2, 32'h44, 32'h0, 1'b0, got); check("lw_44_sw", got, 32'h0123_4567);

        do_req(1'b0, 3'd1, 32'h41, 32'h0, 1'b0, got); check("err_lh41", got, 32'h0);
        do_req(1'b0, 3'd2, 32'h42, 32'h0, 1'b0, got); check("err_lw42", got, 32'h0);
        do_req(1'b0, 3'd3, 32'h40, 32'h0, 1'b0, got); check("err_f3_3", got, 32'h0);
        do_req(1'b0, 3'd2, 32'(4*DW), 32'h0, 1'b0, got); check("err_range", got, 32'h0);
        do_req(1'b1, 3'd1, 32'h41, 32'hDEAD, 1'b0, got);
        do_req(1'b1, 3'd3, 32'h40, 32'hFFFF_FFFF, 1'b0, got);
        do_req(1'b1, 3'd2, 32'(4*DW) + 32'h40, 32'h5555_5555, 1'b0, got);
        do_req(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, got); check("err_no_write", got, 32'hCAFE_12BB);

        // Reset lands in the MERGE cycle of a byte store; the model is deliberately not updated.
        @(negedge clk);
        bus.MemReq = 1'b1;
        bus.MemWrite = 1'b1;
        bus.Funct3 = 3'd0;
        bus.Address = 32'h40;
        bus.WriteData = 32'hFF;
        @(posedge clk);
        #1;
        exp_at = -1;
        @(negedge clk);
        #2;
        reset = 1'b0;
        bus.MemReq = 1'b0;
        exp_hold = '0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        do_req(1'b0, 3'd2, 32'h40, 32'h0, 1'b0, got); check("rst_merge_kept", got, 32'hCAFE_12BB);

        for (int n = 0; n < 300; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            int          r;
            f3 = f3s[$urandom_range(0, 12)];
            r = $urandom_range(0, 9);
            a = r == 0 ? $urandom : 32'($urandom_range(0, 4*DW - 1));
            if (r >= 3) a = a & ~32'(f3[1] ? 3 : f3[0] ? 1 : 0);
            do_req(1'($urandom_range(0, 1)), f3, a, $urandom, 1'($urandom_range(0, 1)), got);
        end

        repeat (2) @(negedge clk);
        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
